// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2c_pkg
// Brief  : Shared state encodings and byte-port constants for the I2C
//          register-transaction controller.
// Rev    : 1.0
// ============================================================================
package i2c_pkg;

  localparam logic [3:0] c_st_idle  = 4'd0;
  localparam logic [3:0] c_st_daddr = 4'd1;
  localparam logic [3:0] c_st_reg   = 4'd2;
  localparam logic [3:0] c_st_wdata = 4'd3;
  localparam logic [3:0] c_st_rstrt = 4'd4;
  localparam logic [3:0] c_st_raddr = 4'd5;
  localparam logic [3:0] c_st_rdata = 4'd6;
  localparam logic [3:0] c_st_stop  = 4'd7;
  localparam logic [3:0] c_st_done  = 4'd8;

  // Per-byte sub-phases: buffer read settle, byte load, strobe, await ack.
  localparam logic [1:0] c_ph_setup = 2'd0;
  localparam logic [1:0] c_ph_load  = 2'd1;
  localparam logic [1:0] c_ph_req   = 2'd2;
  localparam logic [1:0] c_ph_wait  = 2'd3;

  localparam logic [7:0] c_rd_fill  = 8'hff;
  localparam logic       c_addr_wr  = 1'b0;
  localparam logic       c_addr_rd  = 1'b1;

  function automatic logic is_byte_state(input logic [3:0] st);
    return (st == c_st_daddr) || (st == c_st_reg) || (st == c_st_wdata) ||
           (st == c_st_raddr) || (st == c_st_rdata);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bytebuf.sv
`default_nettype none
// ============================================================================
// Module : i2c_bytebuf
// Brief  : MAXLEN x 8 byte buffer, one write port, registered read port.
// Rev    : 1.0
// ============================================================================
module i2c_bytebuf
  import i2c_pkg::*;
#(
  parameter int MAXLEN = 16,
  parameter int LGMAX  = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [LGMAX-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic [LGMAX-1:0] i_raddr,
  output logic [7:0]       o_rdata
);

  logic [7:0] mem_q [MAXLEN];
  logic [7:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/i2c_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : i2c_txn_ctrl
// Brief  : Sequences I2C register read/write transactions onto a byte engine.
// Rev    : 1.0
// ============================================================================
module i2c_txn_ctrl
  import i2c_pkg::*;
#(
  parameter int MAXLEN = 16,
  parameter int LGMAX  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_rd,
  input  logic [6:0]       i_dev,
  input  logic [7:0]       i_reg,
  input  logic [LGMAX-1:0] i_len,
  input  logic             i_wbuf_we,
  input  logic [LGMAX-1:0] i_wbuf_addr,
  input  logic [7:0]       i_wbuf_data,
  input  logic [LGMAX-1:0] i_rbuf_addr,
  output logic [7:0]       o_rbuf_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_cyc,
  output logic             o_stb,
  output logic             o_we,
  output logic [7:0]       o_data,
  input  logic             i_ack,
  input  logic             i_busy,
  input  logic             i_err,
  input  logic [7:0]       i_data
);

  logic [3:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             rd_q, rd_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [LGMAX-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             cyc_q, cyc_d, we_q, we_d;
  logic [7:0]       data_q, data_d;

  logic [7:0]       w_wbuf_rdata, w_byte;
  logic             w_byte_we, w_last, w_stb, w_rbuf_we;

  assign w_last    = (cnt_q == len_q);
  assign w_stb     = cyc_q && !i_busy && (phase_q == c_ph_req) && is_byte_state(state_q);
  assign w_rbuf_we = (state_q == c_st_rdata) && (phase_q == c_ph_wait) && i_ack && !i_err;

  always_comb begin
    w_byte    = c_rd_fill;
    w_byte_we = 1'b1;
    case (state_q)
      c_st_daddr: w_byte = {dev_q, c_addr_wr};
      c_st_reg:   w_byte = reg_q;
      c_st_wdata: w_byte = w_wbuf_rdata;
      c_st_raddr: w_byte = {dev_q, c_addr_rd};
      c_st_rdata: w_byte_we = 1'b0;
      default:    ;
    endcase
  end

  always_comb begin
    state_d = state_q;  phase_d = phase_q;
    rd_d    = rd_q;     dev_d   = dev_q;    reg_d = reg_q;   len_d = len_q;
    cnt_d   = cnt_q;    busy_d  = busy_q;   done_d = 1'b0;   err_d = err_q;
    cyc_d   = cyc_q;    we_d    = we_q;     data_d = data_q;
    case (state_q)
      c_st_idle: begin
        if (i_start) begin
          rd_d = i_rd;  dev_d = i_dev;  reg_d = i_reg;  len_d = i_len;
          err_d = 1'b0; cnt_d = '0;     busy_d = 1'b1;  cyc_d = 1'b1;
          state_d = c_st_daddr;  phase_d = c_ph_setup;
        end
      end
      c_st_rstrt: begin
        cyc_d = 1'b1;  state_d = c_st_raddr;  phase_d = c_ph_setup;
      end
      c_st_stop: begin
        if (!i_busy) begin
          state_d = c_st_done;  done_d = 1'b1;
        end
      end
      c_st_done: begin
        busy_d = 1'b0;  state_d = c_st_idle;
      end
      default: begin
        if (!is_byte_state(state_q)) begin
          state_d = c_st_idle;
        end else begin
          case (phase_q)
            c_ph_setup: phase_d = c_ph_load;
            c_ph_load: begin
              data_d = w_byte;  we_d = w_byte_we;  phase_d = c_ph_req;
            end
            c_ph_req: if (w_stb) phase_d = c_ph_wait;
            default: begin
              // Acks are only meaningful while a strobed byte is outstanding.
              if (i_ack) begin
                phase_d = c_ph_setup;
                if (i_err) begin
                  err_d = 1'b1;  cyc_d = 1'b0;  state_d = c_st_stop;
                end else begin
                  case (state_q)
                    c_st_daddr: state_d = c_st_reg;
                    c_st_reg: begin
                      if (rd_q) begin
                        state_d = c_st_rstrt;  cyc_d = 1'b0;
                      end else begin
                        state_d = c_st_wdata;
                      end
                    end
                    c_st_raddr: begin
                      cnt_d = '0;  state_d = c_st_rdata;
                    end
                    default: begin
                      if (w_last) begin
                        state_d = c_st_stop;  cyc_d = 1'b0;
                      end else begin
                        cnt_d = cnt_q + 1'b1;
                      end
                    end
                  endcase
                end
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= c_st_idle;  phase_q <= c_ph_setup;
      rd_q    <= 1'b0;       dev_q   <= '0;   reg_q  <= '0;   len_q <= '0;
      cnt_q   <= '0;         busy_q  <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      cyc_q   <= 1'b0;       we_q    <= 1'b0; data_q <= '0;
    end else begin
      state_q <= state_d;    phase_q <= phase_d;
      rd_q    <= rd_d;       dev_q   <= dev_d;  reg_q  <= reg_d;  len_q <= len_d;
      cnt_q   <= cnt_d;      busy_q  <= busy_d; done_q <= done_d; err_q <= err_d;
      cyc_q   <= cyc_d;      we_q    <= we_d;   data_q <= data_d;
    end
  end

  i2c_bytebuf #(.MAXLEN(MAXLEN), .LGMAX(LGMAX)) u_wbuf (
    .i_clk(i_clk), .i_we(i_wbuf_we), .i_waddr(i_wbuf_addr), .i_wdata(i_wbuf_data),
    .i_raddr(cnt_q), .o_rdata(w_wbuf_rdata)
  );

  i2c_bytebuf #(.MAXLEN(MAXLEN), .LGMAX(LGMAX)) u_rbuf (
    .i_clk(i_clk), .i_we(w_rbuf_we), .i_waddr(cnt_q), .i_wdata(i_data),
    .i_raddr(i_rbuf_addr), .o_rdata(o_rbuf_data)
  );

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_err  = err_q;
  assign o_cyc  = cyc_q;
  assign o_stb  = w_stb;
  assign o_we   = we_q;
  assign o_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_txn_ctrl
// Brief  : Scoreboard bench for i2c_txn_ctrl with a behavioural byte engine.
// Rev    : 1.0
// ============================================================================
module tb_i2c_txn_ctrl;

  localparam int MAXLEN = 16;
  localparam int LGMAX  = 4;

  logic             clk = 1'b0;
  logic             i_reset, i_start, i_rd, i_wbuf_we;
  logic [6:0]       i_dev;
  logic [7:0]       i_reg, i_wbuf_data, rbuf_data;
  logic [LGMAX-1:0] i_len, i_wbuf_addr, i_rbuf_addr;
  logic             o_busy, o_done, o_err, o_cyc, o_stb, o_we;
  logic [7:0]       o_data;
  logic             eng_ack, eng_busy_w, eng_err_w;
  logic [7:0]       eng_data;

  always #5 clk = ~clk;

  i2c_txn_ctrl #(.MAXLEN(MAXLEN), .LGMAX(LGMAX)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_rd(i_rd),
    .i_dev(i_dev), .i_reg(i_reg), .i_len(i_len),
    .i_wbuf_we(i_wbuf_we), .i_wbuf_addr(i_wbuf_addr), .i_wbuf_data(i_wbuf_data),
    .i_rbuf_addr(i_rbuf_addr), .o_rbuf_data(rbuf_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_data(o_data),
    .i_ack(eng_ack), .i_busy(eng_busy_w), .i_err(eng_err_w), .i_data(eng_data)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- byte engine model ----------------
  logic       m_busy_q, m_err_q, m_bus_q;
  int         m_lat, m_stop_cnt, m_stb_idx;
  int         nak_idx = -1;
  logic [7:0] rdq[$];

  always @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      m_busy_q <= 1'b0; m_err_q <= 1'b0; m_bus_q <= 1'b0; eng_ack <= 1'b0;
      m_lat <= 0; m_stop_cnt <= 0; m_stb_idx <= 0; eng_data <= 8'h00;
    end else begin
      eng_ack <= 1'b0;
      if (o_stb) begin
        m_busy_q <= 1'b1; m_lat <= 2; m_bus_q <= 1'b1;
        m_err_q  <= (m_stb_idx == nak_idx);
        m_stb_idx <= m_stb_idx + 1;
        if (!o_we) eng_data <= (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
      end else if (m_lat > 0) begin
        m_lat <= m_lat - 1;
        if (m_lat == 1) begin
          eng_ack <= 1'b1; m_busy_q <= 1'b0;
        end
      end
      // A one-cycle cyc gap is a repeated start; a longer gap completes a stop.
      if (m_bus_q && !o_cyc) begin
        if (m_stop_cnt == 2) begin
          m_bus_q <= 1'b0; m_stop_cnt <= 0; m_stb_idx <= 0;
        end else begin
          m_stop_cnt <= m_stop_cnt + 1;
        end
      end else begin
        m_stop_cnt <= 0;
      end
    end
  end

  assign eng_busy_w = m_busy_q | (m_bus_q & ~o_cyc);
  assign eng_err_w  = eng_ack & m_err_q;

  // ---------------- monitor / scoreboard ----------------
  logic [8:0] sb[$];
  int done_cnt = 0, cyc_falls = 0, low_run = 0, last_gap = 0;
  logic prev_cyc = 1'b0;

  always @(negedge clk) begin
    if (!i_reset) begin
      if (o_stb) begin
        check_eq("stb_qual", {31'd0, o_cyc && !eng_busy_w}, 32'd1);
        check_eq("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) check_eq("byte", {23'd0, o_we, o_data}, {23'd0, sb.pop_front()});
      end
      if (o_done) begin
        done_cnt++;
        check_eq("done_ibusy", {31'd0, eng_busy_w}, 32'd0);
      end
      if (prev_cyc && !o_cyc && o_busy) cyc_falls++;
      if (o_busy && !o_cyc) low_run++;
      if (o_cyc && !prev_cyc && low_run > 0) begin
        last_gap = low_run;
        low_run  = 0;
      end
      if (!o_busy) low_run = 0;
      prev_cyc = o_cyc;
    end else begin
      prev_cyc = 1'b0;
      low_run  = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_wbuf(input int addr, input logic [7:0] data);
    i_wbuf_we = 1'b1; i_wbuf_addr = addr[LGMAX-1:0]; i_wbuf_data = data;
    @(posedge clk); #1;
    i_wbuf_we = 1'b0;
  endtask

  task automatic start_txn(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                           input int len);
    i_start = 1'b1; i_rd = rd; i_dev = dev; i_reg = rg; i_len = len[LGMAX-1:0];
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    for (int k = 0; k < 400 && done_cnt == d0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_eq(tag, done_cnt - d0, 1);
  endtask

  int d0;
  logic [7:0] exp_rd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] wr3 [3]    = '{8'hA1, 8'hB2, 8'hC3};
  bit seen;

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_rd = 1'b0; i_dev = '0; i_reg = '0; i_len = '0;
    i_wbuf_we = 1'b0; i_wbuf_addr = '0; i_wbuf_data = '0; i_rbuf_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, o_busy}, 0);
    check_eq("rst_done", {31'd0, o_done}, 0);
    check_eq("rst_err",  {31'd0, o_err}, 0);
    check_eq("rst_cyc",  {31'd0, o_cyc}, 0);
    check_eq("rst_stb",  {31'd0, o_stb}, 0);
    check_eq("rst_we",   {31'd0, o_we}, 0);
    check_eq("rst_data", {24'd0, o_data}, 0);
    i_reset = 1'b0;
    @(posedge clk); #1;

    // Register write, three data bytes
    for (int i = 0; i < 3; i++) load_wbuf(i, wr3[i]);
    cyc_falls = 0; d0 = done_cnt;
    sb.push_back({1'b1, 8'hA0}); sb.push_back({1'b1, 8'h10});
    for (int i = 0; i < 3; i++) sb.push_back({1'b1, wr3[i]});
    start_txn(1'b0, 7'h50, 8'h10, 2);
    wait_done("wr_done", d0);
    check_eq("wr_sb_empty", sb.size(), 0);
    check_eq("wr_cyc_falls", cyc_falls, 1);
    check_eq("wr_err", {31'd0, o_err}, 0);
    check_eq("wr_busy", {31'd0, o_busy}, 0);

    // Register read, four data bytes with repeated start
    cyc_falls = 0; d0 = done_cnt; last_gap = 0;
    for (int i = 0; i < 4; i++) rdq.push_back(exp_rd[i]);
    sb.push_back({1'b1, 8'hA0}); sb.push_back({1'b1, 8'h00}); sb.push_back({1'b1, 8'hA1});
    for (int i = 0; i < 4; i++) sb.push_back({1'b0, 8'hFF});
    start_txn(1'b1, 7'h50, 8'h00, 3);
    for (int k = 0; k < 400 && last_gap == 0; k++) @(posedge clk);
    #1;
    check_eq("rd_rstrt_gap", last_gap, 1);
    wait_done("rd_done", d0);
    check_eq("rd_sb_empty", sb.size(), 0);
    check_eq("rd_cyc_falls", cyc_falls, 2);
    check_eq("rd_err", {31'd0, o_err}, 0);
    for (int i = 0; i < 4; i++) begin
      i_rbuf_addr = i[LGMAX-1:0];
      @(posedge clk); #1;
      check_eq($sformatf("rbuf%0d", i), {24'd0, rbuf_data}, {24'd0, exp_rd[i]});
    end

    // NAK on the register byte
    cyc_falls = 0; d0 = done_cnt; nak_idx = 1;
    sb.push_back({1'b1, 8'hA0}); sb.push_back({1'b1, 8'h10});
    start_txn(1'b0, 7'h50, 8'h10, 2);
    wait_done("nak_done", d0);
    nak_idx = -1;
    check_eq("nak_sb_empty", sb.size(), 0);
    check_eq("nak_err", {31'd0, o_err}, 1);
    check_eq("nak_cyc_falls", cyc_falls, 1);

    // Full-length write, no wrap back to slot 0
    for (int i = 0; i < MAXLEN; i++) load_wbuf(i, 8'h80 + i[7:0]);
    d0 = done_cnt;
    sb.push_back({1'b1, 8'hA0}); sb.push_back({1'b1, 8'h20});
    for (int i = 0; i < MAXLEN; i++) sb.push_back({1'b1, 8'h80 + i[7:0]});
    start_txn(1'b0, 7'h50, 8'h20, MAXLEN - 1);
    wait_done("max_done", d0);
    check_eq("max_sb_empty", sb.size(), 0);
    check_eq("max_err_cleared", {31'd0, o_err}, 0);

    // Reset during RDATA, then a fresh transaction
    for (int i = 0; i < 4; i++) rdq.push_back(exp_rd[i]);
    sb.push_back({1'b1, 8'hA0}); sb.push_back({1'b1, 8'h00}); sb.push_back({1'b1, 8'hA1});
    for (int i = 0; i < 4; i++) sb.push_back({1'b0, 8'hFF});
    start_txn(1'b1, 7'h50, 8'h00, 3);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = o_stb && !o_we;
    end
    check_eq("rdata_reached", {31'd0, seen}, 1);
    #2; i_reset = 1'b1; #1;
    check_eq("mid_rst_cyc",  {31'd0, o_cyc}, 0);
    check_eq("mid_rst_stb",  {31'd0, o_stb}, 0);
    check_eq("mid_rst_busy", {31'd0, o_busy}, 0);
    sb.delete(); rdq.delete();
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(posedge clk); #1;
    load_wbuf(0, 8'h5A);
    d0 = done_cnt;
    sb.push_back({1'b1, 8'hA0}); sb.push_back({1'b1, 8'h30}); sb.push_back({1'b1, 8'h5A});
    start_txn(1'b0, 7'h50, 8'h30, 0);
    wait_done("post_rst_done", d0);
    check_eq("post_rst_sb_empty", sb.size(), 0);

    // i_start while busy and coincident with DONE is ignored
    d0 = done_cnt;
    sb.push_back({1'b1, 8'h44}); sb.push_back({1'b1, 8'h33}); sb.push_back({1'b1, 8'h5A});
    start_txn(1'b0, 7'h22, 8'h33, 0);
    repeat (4) @(posedge clk);
    #1;
    start_txn(1'b1, 7'h11, 8'h77, 1);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = o_done;
    end
    check_eq("done_seen", {31'd0, seen}, 1);
    check_eq("busy_at_done", {31'd0, o_busy}, 1);
    i_start = 1'b1; i_rd = 1'b1; i_dev = 7'h11; i_reg = 8'h77; i_len = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("ign_done_cnt", done_cnt - d0, 1);
    check_eq("ign_sb_empty", sb.size(), 0);
    check_eq("ign_busy", {31'd0, o_busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
